// File: rtl/tri_stream_pkg.sv
// Shared types, sizes and helpers for the rasterizer triangle feeder.
package tri_stream_pkg;

  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 32;
  localparam int OCC_W  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] verts_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]                 color_t;
  typedef logic [CNT_W-1:0]                              cnt_t;

  typedef struct packed {
    verts_t verts;
    color_t color;
  } tri_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v, input logic en);
    cnt_t r;
    if (en && (v != {CNT_W{1'b1}})) r = v + cnt_t'(1);
    else                            r = v;
    return r;
  endfunction

endpackage

// File: rtl/tri_stream_if.sv
// Host push side and R10 rasterizer side of the triangle feeder.
interface tri_stream_if;
  import tri_stream_pkg::*;

  verts_t push_tri_S;
  color_t push_color_U;
  logic   push_valid_H;
  logic   push_ready_H;
  logic   frame_end_H;

  verts_t tri_R10S;
  color_t color_R10U;
  logic   validTri_R10H;
  logic   halt_RnnnnL;
  logic   frame_done_H;

  modport master (
    input  push_tri_S, push_color_U, push_valid_H, frame_end_H, halt_RnnnnL,
    output push_ready_H, tri_R10S, color_R10U, validTri_R10H, frame_done_H
  );

  modport slave (
    output push_tri_S, push_color_U, push_valid_H, frame_end_H, halt_RnnnnL,
    input  push_ready_H, tri_R10S, color_R10U, validTri_R10H, frame_done_H
  );

endinterface

// File: rtl/tri_stream_fifo.sv
// Small synchronous FIFO of triangles; extra pointer MSB separates full from empty.
module tri_stream_fifo
  import tri_stream_pkg::*;
#(
  parameter int D = DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  tri_t                     i_wr_data,
  input  logic                     i_rd_en,
  output tri_t                     o_rd_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(D+1)-1:0]   o_occupancy
);

  localparam int PTR_W = $clog2(D);
  localparam int OW    = $clog2(D + 1);

  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  tri_t           r_mem [D];
  logic           w_wr;
  logic           w_rd;

  assign o_empty     = (r_wr_ptr == r_rd_ptr);
  assign o_full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_wr        = i_wr_en && !o_full;
  assign w_rd        = i_rd_en && !o_empty;
  assign o_rd_data   = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign o_occupancy = OW'(r_wr_ptr - r_rd_ptr);

  // Pointer update; reset empties the FIFO immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/tri_stream_feeder.sv
// Triangle source for the rasterizer: FIFO, output register under halt
// backpressure, frame-boundary FSM and saturating performance counters.
module tri_stream_feeder
  import tri_stream_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  tri_stream_if.master       bus,
  output logic [OCC_W-1:0]   occupancy,
  output cnt_t               tri_sent_count,
  output cnt_t               stall_count
);

  state_t           r_state;
  state_t           w_state_next;
  tri_t             r_out;
  logic             r_valid;
  logic             r_frame_done;
  cnt_t             r_sent;
  cnt_t             r_stall;

  tri_t             w_push_data;
  tri_t             w_head;
  logic             w_empty;
  logic             w_full;
  logic [OCC_W-1:0] w_occ;
  logic             w_push_ready;
  logic             w_push_acc;
  logic             w_xfer;
  logic             w_load;
  logic             w_drained;

  assign w_push_data.verts = bus.push_tri_S;
  assign w_push_data.color = bus.push_color_U;

  assign w_push_ready = !w_full && (r_state != DRAIN) && (r_state != DONE);
  assign w_push_acc   = bus.push_valid_H && w_push_ready;
  assign w_xfer       = r_valid && bus.halt_RnnnnL;
  assign w_load       = !w_empty && (!r_valid || w_xfer);
  assign w_drained    = w_empty && (!r_valid || w_xfer);

  tri_stream_fifo #(.D(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_wr_en     (w_push_acc),
    .i_wr_data   (w_push_data),
    .i_rd_en     (w_load),
    .o_rd_data   (w_head),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_occupancy (w_occ)
  );

  // Output register: refill from the head when free or emptying, hold under halt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_out   <= w_head;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  // Frame FSM; a push arriving with frame_end in IDLE still belongs to the frame.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.frame_end_H) w_state_next = w_push_acc ? DRAIN : DONE;
        else if (w_push_acc) w_state_next = RUN;
        else                 w_state_next = IDLE;
      end
      RUN: begin
        if (bus.frame_end_H) w_state_next = DRAIN;
        else                 w_state_next = RUN;
      end
      DRAIN: begin
        if (w_drained) w_state_next = DONE;
        else           w_state_next = DRAIN;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State, frame-done pulse and saturating counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_frame_done <= 1'b0;
      r_sent       <= '0;
      r_stall      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_frame_done <= (w_state_next == DONE);
      r_sent       <= sat_inc(r_sent, w_xfer);
      r_stall      <= sat_inc(r_stall, r_valid && !bus.halt_RnnnnL);
    end
  end

  assign bus.push_ready_H  = w_push_ready;
  assign bus.tri_R10S      = r_out.verts;
  assign bus.color_R10U    = r_out.color;
  assign bus.validTri_R10H = r_valid;
  assign bus.frame_done_H  = r_frame_done;
  assign occupancy         = w_occ;
  assign tri_sent_count    = r_sent;
  assign stall_count       = r_stall;

endmodule

// File: tb/tb_tri_stream_feeder.sv
// Scoreboard bench for tri_stream_feeder: directed pushes queue expected
// triangles, a negedge monitor checks every presented triangle in order.
module tb_tri_stream_feeder;
  import tri_stream_pkg::*;

  logic             clk;
  logic             rst;
  logic [OCC_W-1:0] occupancy;
  cnt_t             sent;
  cnt_t             stall;

  tri_stream_if bus();

  tri_stream_feeder dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .occupancy      (occupancy),
    .tri_sent_count (sent),
    .stall_count    (stall)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   fd_count = 0;
  tri_t exp_q[$];
  tri_t mon_act;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tri_t mk(input int s);
    tri_t t;
    t = '0;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++) begin
        t.verts[v][a] = 24'(s * 256 + v * 16 + a);
        if (a == 1) t.verts[v][a] = -t.verts[v][a];
      end
    for (int c = 0; c < COLORS; c++) t.color[c] = 24'(s * 4096 + c + 1);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int s, input logic exp_acc);
    tri_t t;
    t = mk(s);
    bus.push_tri_S   = t.verts;
    bus.push_color_U = t.color;
    bus.push_valid_H = 1'b1;
    chk("push_ready", 64'(bus.push_ready_H), 64'(exp_acc));
    if (exp_acc) exp_q.push_back(t);
    tick();
    bus.push_valid_H = 1'b0;
  endtask

  task automatic frame_end();
    bus.frame_end_H = 1'b1;
    tick();
    bus.frame_end_H = 1'b0;
  endtask

  // Monitor: every presented triangle must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bus.validTri_R10H) begin
      mon_act.verts = bus.tri_R10S;
      mon_act.color = bus.color_R10U;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got %0h expected no triangle", mon_act);
      end else begin
        if (mon_act !== exp_q[0]) begin
          n_fail++;
          $display("FAIL out_data: got %0h expected %0h", mon_act, exp_q[0]);
        end
        if (bus.halt_RnnnnL) void'(exp_q.pop_front());
      end
    end
    if (!rst && bus.frame_done_H) fd_count++;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus.halt_RnnnnL  = 1'b1;
    bus.push_valid_H = 1'b0;
    bus.frame_end_H  = 1'b0;
    bus.push_tri_S   = '0;
    bus.push_color_U = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",      64'(bus.validTri_R10H), 64'd0);
    chk("rst_tri_zero",   64'(bus.tri_R10S != '0), 64'd0);
    chk("rst_color_zero", 64'(bus.color_R10U != '0), 64'd0);
    chk("rst_frame_done", 64'(bus.frame_done_H), 64'd0);
    chk("rst_occupancy",  64'(occupancy), 64'd0);
    chk("rst_sent",       64'(sent), 64'd0);
    chk("rst_stall",      64'(stall), 64'd0);
    chk("rst_push_ready", 64'(bus.push_ready_H), 64'd1);
    rst = 1'b0;
    tick();

    // back-to-back frame of three
    push(1, 1'b1); chk("t1_valid_c1", 64'(bus.validTri_R10H), 64'd0);
    push(2, 1'b1); chk("t1_valid_c2", 64'(bus.validTri_R10H), 64'd1);
    push(3, 1'b1); chk("t1_valid_c3", 64'(bus.validTri_R10H), 64'd1);
    frame_end();   chk("t1_valid_c4", 64'(bus.validTri_R10H), 64'd1);
    push(99, 1'b0);
    chk("t1_frame_done", 64'(bus.frame_done_H), 64'd1);
    chk("t1_valid_end",  64'(bus.validTri_R10H), 64'd0);
    chk("t1_sent",       64'(sent), 64'd3);
    tick();
    chk("t1_fd_single",  64'(bus.frame_done_H), 64'd0);
    chk("t1_idle_ready", 64'(bus.push_ready_H), 64'd1);
    chk("t1_fd_count",   64'(fd_count), 64'd1);

    // five stalled cycles then release
    bus.halt_RnnnnL = 1'b0;
    push(4, 1'b1);
    tick();
    repeat (5) tick();
    chk("t2_stall",      64'(stall), 64'd5);
    chk("t2_valid_held", 64'(bus.validTri_R10H), 64'd1);
    bus.halt_RnnnnL = 1'b1;
    tick();
    chk("t2_sent",       64'(sent), 64'd4);
    chk("t2_valid_off",  64'(bus.validTri_R10H), 64'd0);

    // fill under halt until refused
    bus.halt_RnnnnL = 1'b0;
    for (int i = 5; i <= 9; i++) push(i, 1'b1);
    chk("t3_occ_full",   64'(occupancy), 64'd4);
    push(10, 1'b0);
    chk("t3_occ_held",   64'(occupancy), 64'd4);
    chk("t3_stall",      64'(stall), 64'd9);

    // push refused while full even though a transfer happens
    bus.halt_RnnnnL = 1'b1;
    push(10, 1'b0);
    chk("t4_occ_pop",    64'(occupancy), 64'd3);
    chk("t4_sent",       64'(sent), 64'd5);
    bus.halt_RnnnnL = 1'b0;
    push(10, 1'b1);
    chk("t4_occ_refill", 64'(occupancy), 64'd4);
    chk("t4_stall",      64'(stall), 64'd10);
    bus.halt_RnnnnL = 1'b1;
    repeat (6) tick();
    chk("t4_sent_all",   64'(sent), 64'd10);
    chk("t4_occ_empty",  64'(occupancy), 64'd0);
    chk("t4_q_empty",    64'(exp_q.size()), 64'd0);
    frame_end();
    tick();
    tick();
    chk("t4_fd_count",   64'(fd_count), 64'd2);

    // empty frame
    frame_end();
    chk("t5_frame_done", 64'(bus.frame_done_H), 64'd1);
    chk("t5_sent",       64'(sent), 64'd10);
    tick();
    chk("t5_fd_single",  64'(bus.frame_done_H), 64'd0);
    chk("t5_fd_count",   64'(fd_count), 64'd3);

    // reset mid-DRAIN with two entries queued
    bus.halt_RnnnnL = 1'b0;
    push(11, 1'b1);
    push(12, 1'b1);
    push(13, 1'b1);
    frame_end();
    chk("t6_occ_two",     64'(occupancy), 64'd2);
    chk("t6_drain_ready", 64'(bus.push_ready_H), 64'd0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_valid",      64'(bus.validTri_R10H), 64'd0);
    chk("t6_occ",        64'(occupancy), 64'd0);
    chk("t6_sent",       64'(sent), 64'd0);
    chk("t6_stall",      64'(stall), 64'd0);
    chk("t6_frame_done", 64'(bus.frame_done_H), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_fd",      64'(bus.frame_done_H), 64'd0);
    chk("t6_fd_count",   64'(fd_count), 64'd3);
    rst = 1'b0;
    tick();
    chk("t6_ready",      64'(bus.push_ready_H), 64'd1);
    chk("t6_valid_post", 64'(bus.validTri_R10H), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
